// File: rtl/soc_design_pio_pkg.sv
// Shared constants for the PIO bank: register offsets inside a channel's
// eight-word window and the word-address width helper.
package soc_design_pio_pkg;

    localparam int BUS_W = 32;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_SET  = 3'd1;
    localparam logic [2:0] REG_CLR  = 3'd2;
    localparam logic [2:0] REG_TGL  = 3'd3;
    localparam logic [2:0] REG_IN   = 3'd4;
    localparam logic [2:0] REG_EDGE = 3'd5;
    localparam logic [2:0] REG_MASK = 3'd6;
    localparam logic [2:0] REG_RSVD = 3'd7;

    // Word address = {channel, reg[2:0]}
    function automatic int addr_w(input int num_ch);
        return $clog2(num_ch) + 3;
    endfunction

endpackage

// File: rtl/soc_design_pio_bank_if.sv
// Avalon-MM slave bus bundle for the PIO bank (word addressed, read latency 1).
interface soc_design_pio_bank_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_design_pio_chan.sv
// One PIO channel: output DATA register with set/clear/toggle aliases,
// two-flop input synchroniser, rising-edge capture, interrupt mask and the
// channel-local read mux.
module soc_design_pio_chan
    import soc_design_pio_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en_i,
    input  logic [2:0]        reg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] in_i,
    output logic [DATA_W-1:0] data_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              irq_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] sync1_q;
    logic [DATA_W-1:0] sync2_q;
    logic [DATA_W-1:0] prev_q;
    logic [DATA_W-1:0] edge_q;
    logic [DATA_W-1:0] edge_d;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] mask_d;
    logic [DATA_W-1:0] rise_s;
    logic [DATA_W-1:0] clr_s;

    assign rise_s = sync2_q & ~prev_q;

    // Next-state for DATA, IRQMASK and EDGE; a new rise beats a same-cycle clear.
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        clr_s  = '0;
        if (wr_en_i) begin
            case (reg_i)
                REG_DATA: data_d = wdata_i;
                REG_SET:  data_d = data_q | wdata_i;
                REG_CLR:  data_d = data_q & ~wdata_i;
                REG_TGL:  data_d = data_q ^ wdata_i;
                REG_EDGE: clr_s  = wdata_i;
                REG_MASK: mask_d = wdata_i;
                default:  data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end
        edge_d = (edge_q & ~clr_s) | rise_s;
    end

    // Channel state registers, including the input synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_VAL;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            edge_q  <= '0;
            mask_q  <= '0;
        end else begin
            data_q  <= data_d;
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= edge_d;
            mask_q  <= mask_d;
        end
    end

    // Read mux; write-only aliases and the reserved slot read as zero.
    always_comb begin
        case (reg_i)
            REG_DATA: rd_data_o = data_q;
            REG_IN:   rd_data_o = sync2_q;
            REG_EDGE: rd_data_o = edge_q;
            REG_MASK: rd_data_o = mask_q;
            default:  rd_data_o = '0;
        endcase
    end

    assign data_o = data_q;
    assign irq_o  = |(edge_q & mask_q);

endmodule

// File: rtl/soc_design_pio_bank.sv
// Multi-channel Avalon-MM PIO bank: decodes {channel, reg} addresses, fans
// writes out to the channels, registers read data and ORs channel interrupts.
module soc_design_pio_bank
    import soc_design_pio_pkg::*;
#(
    parameter int                NUM_CH    = 4,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    soc_design_pio_bank_if.slave     bus,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic                     irq
);

    localparam int ADDR_W = addr_w(NUM_CH);
    // One spare MSB keeps the channel field at least one bit wide when NUM_CH=1.
    localparam int CH_W   = ADDR_W - 2;

    logic [ADDR_W:0]     addr_ext_s;
    logic [CH_W-1:0]     chan_s;
    logic [2:0]          reg_s;
    logic                wr_s;
    logic                rd_s;
    logic [DATA_W-1:0]   wdata_s;
    logic                unused_wdata_s;
    logic [NUM_CH-1:0]   wr_sel_s;
    logic [NUM_CH-1:0]   irq_ch_s;
    logic [DATA_W-1:0]   rd_data_s [NUM_CH];
    logic [DATA_W-1:0]   rd_mux_s;
    logic [BUS_W-1:0]    readdata_q;
    logic [BUS_W-1:0]    readdata_d;

    assign addr_ext_s     = {1'b0, bus.address};
    assign chan_s         = addr_ext_s[ADDR_W:3];
    assign reg_s          = bus.address[2:0];
    assign wr_s           = bus.chipselect & ~bus.write_n;
    assign rd_s           = bus.chipselect & ~bus.read_n;
    assign wdata_s        = bus.writedata[DATA_W-1:0];
    assign unused_wdata_s = ^bus.writedata;

    // Per-channel write enables; out-of-range channels match nothing.
    always_comb begin
        wr_sel_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_s && (int'(chan_s) == c)) begin
                wr_sel_s[c] = 1'b1;
            end else begin
                wr_sel_s[c] = 1'b0;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        soc_design_pio_chan #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr_en_i   (wr_sel_s[c]),
            .reg_i     (reg_s),
            .wdata_i   (wdata_s),
            .in_i      (in_port[c*DATA_W +: DATA_W]),
            .data_o    (out_port[c*DATA_W +: DATA_W]),
            .rd_data_o (rd_data_s[c]),
            .irq_o     (irq_ch_s[c])
        );
    end

    // Select the addressed channel's read data; unmapped channels return zero.
    always_comb begin
        rd_mux_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(chan_s) == c) begin
                rd_mux_s = rd_data_s[c];
            end else begin
                rd_mux_s = rd_mux_s;
            end
        end
    end

    // Capture read data on a read strobe (pre-write state), otherwise hold.
    always_comb begin
        if (rd_s) begin
            readdata_d = BUS_W'(rd_mux_s);
        end else begin
            readdata_d = readdata_q;
        end
    end

    // Registered read data, cleared immediately by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= 32'h0000_0000;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |irq_ch_s;

endmodule
